// File: rtl/board_b_mixer.sv
// Two-stage pixel priority mixer for layer A, layer B (with 0-3 pixel extra delay) and sprites.
// Produces a palette address {sel, col, bit} plus a visible-pixel flag.
`timescale 1ns/1ps
module board_b_mixer (
  input  logic       CLK_32M,
  input  logic       RESET,
  input  logic       CE_PIX,
  input  logic [3:0] A_BIT,
  input  logic [3:0] A_COL,
  input  logic       A_CP15,
  input  logic       A_CP8,
  input  logic [3:0] B_BIT,
  input  logic [3:0] B_COL,
  input  logic       B_CP15,
  input  logic       B_CP8,
  input  logic [3:0] OBJ_BIT,
  input  logic [3:0] OBJ_COL,
  input  logic       HBLK,
  input  logic       VBLK,
  input  logic [1:0] B_DLY,
  input  logic [2:0] LAYER_EN,
  output logic [9:0] PAL_ADDR,
  output logic       PIX_VALID
);

  typedef struct packed {
    logic [3:0] bits;
    logic [3:0] col;
    logic       cp15;
    logic       cp8;
  } layer_t;

  localparam logic [1:0] SEL_OBJ  = 2'd0;
  localparam logic [1:0] SEL_A    = 2'd1;
  localparam logic [1:0] SEL_B    = 2'd2;
  localparam logic [1:0] SEL_BACK = 2'd3;

  layer_t     a_q;
  layer_t     b_sr [4];
  layer_t     b_tap;
  logic [3:0] obj_bit_q;
  logic [3:0] obj_col_q;
  logic [2:0] en_q;
  logic       blank_q;
  logic       valid_q;   // stage 1 holds a real pixel (cleared by reset)

  // Stage 1: register every input; layer B also enters its delay line.
  always_ff @(posedge CLK_32M) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      a_q       <= '0;
      obj_bit_q <= '0;
      obj_col_q <= '0;
      en_q      <= '0;
      blank_q   <= 1'b0;
      valid_q   <= 1'b0;
      // NOTE: the B delay line is small and must read transparent after reset, so it is cleared like any register.
      for (int i = 0; i < 4; i++) b_sr[i] <= '0;
    end else if (CE_PIX) begin
      a_q       <= {A_BIT, A_COL, A_CP15, A_CP8};
      obj_bit_q <= OBJ_BIT;
      obj_col_q <= OBJ_COL;
      en_q      <= LAYER_EN;
      blank_q   <= HBLK | VBLK;
      valid_q   <= 1'b1;
      b_sr[0]   <= {B_BIT, B_COL, B_CP15, B_CP8};
      for (int i = 1; i < 4; i++) b_sr[i] <= b_sr[i-1];
    end
  end

  // Tap selected live, so a B_DLY change lands on the next CE_PIX without flushing the line.
  assign b_tap = b_sr[B_DLY];

  logic       a_op;
  logic       b_op;
  logic       obj_op;
  logic [9:0] next_addr;
  logic       next_valid;

  assign a_op   = (a_q.bits   != 4'd0) && en_q[0];
  assign b_op   = (b_tap.bits != 4'd0) && en_q[1];
  assign obj_op = (obj_bit_q  != 4'd0) && en_q[2];

  // Stage 2 precedence; a priority flag only counts on an opaque, enabled pixel.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    next_addr  = {SEL_BACK, 8'h00};
    next_valid = valid_q && !blank_q;
    if (!next_valid)                        next_addr = '0;
    else if (a_op && (a_q.cp15 || a_q.cp8)) next_addr = {SEL_A, a_q.col, a_q.bits};
    else if (b_op && (b_tap.cp15 || b_tap.cp8))
                                            next_addr = {SEL_B, b_tap.col, b_tap.bits};
    else if (obj_op)                        next_addr = {SEL_OBJ, obj_col_q, obj_bit_q};
    else if (a_op)                          next_addr = {SEL_A, a_q.col, a_q.bits};
    else if (b_op)                          next_addr = {SEL_B, b_tap.col, b_tap.bits};
  end

  always_ff @(posedge CLK_32M) begin
    if (RESET) begin
      PAL_ADDR  <= '0;
      PIX_VALID <= 1'b0;
    end else if (CE_PIX) begin
      PAL_ADDR  <= next_addr;
      PIX_VALID <= next_valid;
    end
  end

endmodule

// File: tb/tb_board_b_mixer.sv
// Self-checking bench for board_b_mixer: directed vector table, hand-written
// delay/hold/reset sequences, then randomized traffic against a pixel-history model.
`timescale 1ns/1ps
module tb_board_b_mixer;

  typedef struct packed {
    logic [3:0] a_bit;
    logic [3:0] a_col;
    logic       a_cp15;
    logic       a_cp8;
    logic [3:0] b_bit;
    logic [3:0] b_col;
    logic       b_cp15;
    logic       b_cp8;
    logic [3:0] o_bit;
    logic [3:0] o_col;
    logic       hblk;
    logic       vblk;
    logic [2:0] en;
  } pix_t;

  typedef struct {
    pix_t       pix;
    logic [9:0] addr;
    logic       valid;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b0;
  logic [3:0] a_bit, a_col, b_bit, b_col, o_bit, o_col;
  logic       a_cp15, a_cp8, b_cp15, b_cp8, hblk, vblk;
  logic [1:0] b_dly = 2'd0;
  logic [2:0] en;
  logic [9:0] pal_addr;
  logic       pix_valid;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  board_b_mixer dut (
    .CLK_32M(clk), .RESET(rst), .CE_PIX(ce),
    .A_BIT(a_bit), .A_COL(a_col), .A_CP15(a_cp15), .A_CP8(a_cp8),
    .B_BIT(b_bit), .B_COL(b_col), .B_CP15(b_cp15), .B_CP8(b_cp8),
    .OBJ_BIT(o_bit), .OBJ_COL(o_col), .HBLK(hblk), .VBLK(vblk),
    .B_DLY(b_dly), .LAYER_EN(en),
    .PAL_ADDR(pal_addr), .PIX_VALID(pix_valid)
  );

  function automatic pix_t mkpix(logic [3:0] ab, logic [3:0] ac, logic a15, logic a8,
                                 logic [3:0] bb, logic [3:0] bc, logic b15, logic b8,
                                 logic [3:0] ob, logic [3:0] oc, logic hb, logic vb,
                                 logic [2:0] e);
    pix_t p;
    p = '{a_bit: ab, a_col: ac, a_cp15: a15, a_cp8: a8, b_bit: bb, b_col: bc,
          b_cp15: b15, b_cp8: b8, o_bit: ob, o_col: oc, hblk: hb, vblk: vb, en: e};
    return p;
  endfunction

  task automatic drive(input pix_t p);
    a_bit = p.a_bit; a_col = p.a_col; a_cp15 = p.a_cp15; a_cp8 = p.a_cp8;
    b_bit = p.b_bit; b_col = p.b_col; b_cp15 = p.b_cp15; b_cp8 = p.b_cp8;
    o_bit = p.o_bit; o_col = p.o_col; hblk = p.hblk; vblk = p.vblk; en = p.en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [10:0] exp);
    vectors++;
    if ({pix_valid, pal_addr} !== exp) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b addr=%03h, expected valid=%0b addr=%03h",
               name, pix_valid, pal_addr, exp[10], exp[9:0]);
    end
  endtask

  // Reference: list of candidate sources in precedence order, first qualifying one wins.
  function automatic logic [10:0] ref_mix(input pix_t cur, input pix_t bsrc);
    logic [9:0] cand [5];
    logic       ok   [5];
    if (cur.hblk || cur.vblk) return 11'd0;
    cand[0] = {2'd1, cur.a_col, cur.a_bit};
    ok[0]   = cur.en[0] && cur.a_bit != 0 && (cur.a_cp15 || cur.a_cp8);
    cand[1] = {2'd2, bsrc.b_col, bsrc.b_bit};
    ok[1]   = cur.en[1] && bsrc.b_bit != 0 && (bsrc.b_cp15 || bsrc.b_cp8);
    cand[2] = {2'd0, cur.o_col, cur.o_bit};
    ok[2]   = cur.en[2] && cur.o_bit != 0;
    cand[3] = cand[0];
    ok[3]   = cur.en[0] && cur.a_bit != 0;
    cand[4] = cand[1];
    ok[4]   = cur.en[1] && bsrc.b_bit != 0;
    for (int i = 0; i < 5; i++) if (ok[i]) return {1'b1, cand[i]};
    return {1'b1, 10'h300};
  endfunction

  function automatic pix_t rand_pix();
    pix_t p;
    p = pix_t'({$urandom, $urandom});
    if ($urandom_range(2) == 0) p.a_bit = 4'd0;
    if ($urandom_range(2) == 0) p.b_bit = 4'd0;
    if ($urandom_range(2) == 0) p.o_bit = 4'd0;
    p.a_cp15 = ($urandom_range(3) == 0);
    p.b_cp15 = ($urandom_range(3) == 0);
    p.hblk   = ($urandom_range(9) == 0);
    p.vblk   = ($urandom_range(19) == 0);
    if ($urandom_range(1) == 0) p.en = 3'b111;
    return p;
  endfunction

  vec_t vecs [13];
  pix_t hist [$];

  initial begin
    vecs[0]  = '{mkpix(5,3,0,0, 0,0,0,0, 2,7, 0,0, 3'b111), 10'h072, 1'b1, "a_low_vs_obj"};
    vecs[1]  = '{mkpix(5,3,1,0, 0,0,0,0, 2,7, 0,0, 3'b111), 10'h135, 1'b1, "a_cp15_vs_obj"};
    vecs[2]  = '{mkpix(0,3,1,0, 0,0,0,0, 2,7, 0,0, 3'b111), 10'h072, 1'b1, "a_cp15_transparent"};
    vecs[3]  = '{mkpix(0,0,0,0, 0,0,0,0, 0,0, 0,0, 3'b111), 10'h300, 1'b1, "backdrop"};
    vecs[4]  = '{mkpix(5,3,1,0, 0,0,0,0, 0,0, 1,0, 3'b111), 10'h000, 1'b0, "hblank"};
    vecs[5]  = '{mkpix(5,3,0,0, 9,4,0,0, 2,7, 0,1, 3'b111), 10'h000, 1'b0, "vblank"};
    vecs[6]  = '{mkpix(5,3,1,0, 9,4,0,0, 0,0, 0,0, 3'b110), 10'h249, 1'b1, "a_disabled"};
    vecs[7]  = '{mkpix(5,3,0,1, 0,0,0,0, 2,7, 0,0, 3'b111), 10'h135, 1'b1, "a_cp8_vs_obj"};
    vecs[8]  = '{mkpix(5,3,0,0, 9,4,0,1, 2,7, 0,0, 3'b111), 10'h249, 1'b1, "b_cp8_vs_obj"};
    vecs[9]  = '{mkpix(5,3,0,0, 9,4,0,0, 0,0, 0,0, 3'b111), 10'h135, 1'b1, "a_low_vs_b_low"};
    vecs[10] = '{mkpix(0,0,0,0, 9,4,0,0, 2,7, 0,0, 3'b011), 10'h249, 1'b1, "obj_disabled"};
    vecs[11] = '{mkpix(5,3,1,0, 9,4,1,0, 2,7, 0,0, 3'b111), 10'h135, 1'b1, "a_hi_vs_b_hi"};
    vecs[12] = '{mkpix(0,0,0,0, 9,4,1,1, 2,7, 0,0, 3'b101), 10'h072, 1'b1, "b_flags_disabled"};

    drive('0);
    tick();
    check("reset_state", 11'd0);
    rst = 1'b0;

    // Directed table: hold each vector for two CE_PIX so both stages carry it.
    ce = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].pix);
      tick();
      tick();
      check(vecs[i].name, {vecs[i].valid, vecs[i].addr});
    end

    // Single B pixel through a 2-pixel delay, then hold and reset.
    rst = 1'b1; tick(); rst = 1'b0;
    b_dly = 2'd2;
    drive(mkpix(0,0,0,0, 9,4,0,0, 0,0, 0,0, 3'b111));
    tick(); check("bdly_ce1", 11'd0);
    drive(mkpix(0,0,0,0, 0,0,0,0, 0,0, 0,0, 3'b111));
    tick(); check("bdly_ce2", {1'b1, 10'h300});
    tick(); check("bdly_ce3", {1'b1, 10'h300});
    tick(); check("bdly_ce4", {1'b1, 10'h249});
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(rand_pix());
      tick(); check("ce_hold", {1'b1, 10'h249});
    end
    drive(mkpix(0,0,0,0, 0,0,0,0, 0,0, 0,0, 3'b111));
    ce = 1'b1;
    tick(); check("bdly_ce5", {1'b1, 10'h300});
    ce = 1'b0; rst = 1'b1;
    tick(); check("reset_pulse", 11'd0);
    rst = 1'b0;

    // Randomized traffic against the pixel-history model.
    hist.delete();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      pix_t p;
      logic [10:0] exp_q;
      if ($urandom_range(63) == 0) b_dly = 2'($urandom);
      p   = rand_pix();
      rst = ($urandom_range(299) == 0);
      ce  = ($urandom_range(3) != 0);
      drive(p);
      if (cyc == 0) exp_q = 11'd0;
      else          exp_q = {pix_valid, pal_addr};
      if (rst) begin
        hist.delete();
        exp_q = 11'd0;
      end else if (ce) begin
        int n;
        int bi;
        hist.push_back(p);
        n  = hist.size();
        bi = n - 2 - int'(b_dly);
        if (n < 2) exp_q = 11'd0;
        else       exp_q = ref_mix(hist[n-2], (bi >= 0) ? hist[bi] : pix_t'('0));
      end
      tick();
      check("random", exp_q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
